// File: rtl/mult_batch_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | mult_batch_pkg                                                     |
// | State encoding and shared constants for the batch multiply sequencer|
// | Rev 1.0 - initial release                                          |
// +--------------------------------------------------------------------+
package mult_batch_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE   = 3'd0;
  localparam state_t ST_LOAD_A = 3'd1;
  localparam state_t ST_LOAD_B = 3'd2;
  localparam state_t ST_MULT   = 3'd3;
  localparam state_t ST_STORE  = 3'd4;
  localparam state_t ST_FINISH = 3'd5;

  localparam int RF_A_IDX  = 0;
  localparam int RF_B_IDX  = 1;
  localparam int MAX_PAIRS = 8;

endpackage
`default_nettype wire

// File: rtl/mult_batch_ctrl_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | mult_batch_ctrl_if                                                 |
// | Job request and datapath strobe bundle for mult_batch_ctrl         |
// | Rev 1.0 - initial release                                          |
// +--------------------------------------------------------------------+
interface mult_batch_ctrl_if #(
  parameter int ADDR_W    = 3,
  parameter int RF_ADDR_W = 2,
  parameter int CNT_W     = 4
);
  logic                 start;
  logic [ADDR_W-1:0]    base_a;
  logic [ADDR_W-1:0]    base_b;
  logic [ADDR_W-1:0]    base_r;
  logic [CNT_W-1:0]     count;
  logic [ADDR_W-1:0]    rom_addr;
  logic                 rf_w;
  logic [RF_ADDR_W-1:0] rf_w_addr;
  logic [ADDR_W-1:0]    ram_addr;
  logic                 ram_w;
  logic                 busy;
  logic                 done;

  modport master (
    output start, base_a, base_b, base_r, count,
    input  rom_addr, rf_w, rf_w_addr, ram_addr, ram_w, busy, done
  );

  modport slave (
    input  start, base_a, base_b, base_r, count,
    output rom_addr, rf_w, rf_w_addr, ram_addr, ram_w, busy, done
  );
endinterface
`default_nettype wire

// File: rtl/mult_batch_addr_gen.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | mult_batch_addr_gen                                                |
// | Latched job bases + pair index; wrapped ROM/RAM address generation |
// | Rev 1.0 - initial release                                          |
// +--------------------------------------------------------------------+
module mult_batch_addr_gen #(
  parameter int ADDR_W = 3,
  parameter int CNT_W  = 4
) (
  input  wire logic              clk,
  input  wire logic              rst,
  input  wire logic              i_latch,
  input  wire logic [ADDR_W-1:0] i_base_a,
  input  wire logic [ADDR_W-1:0] i_base_b,
  input  wire logic [ADDR_W-1:0] i_base_r,
  input  wire logic              i_inc,
  input  wire logic              i_sel_a,
  input  wire logic              i_sel_b,
  input  wire logic              i_sel_r,
  output logic      [CNT_W-1:0]  o_idx,
  output logic      [ADDR_W-1:0] o_rom_addr,
  output logic      [ADDR_W-1:0] o_ram_addr
);
  logic [ADDR_W-1:0] r_base_a;
  logic [ADDR_W-1:0] r_base_b;
  logic [ADDR_W-1:0] r_base_r;
  logic [CNT_W-1:0]  r_idx;
  logic [ADDR_W-1:0] r_rom_hold;
  logic [ADDR_W-1:0] r_ram_hold;
  logic [ADDR_W-1:0] w_addr_a;
  logic [ADDR_W-1:0] w_addr_b;
  logic [ADDR_W-1:0] w_addr_r;

  // Sums truncate to ADDR_W, giving the modulo-2^ADDR_W wrap for free
  assign w_addr_a = r_base_a + ADDR_W'(r_idx);
  assign w_addr_b = r_base_b + ADDR_W'(r_idx);
  assign w_addr_r = r_base_r + ADDR_W'(r_idx);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_base_a   <= '0;
      r_base_b   <= '0;
      r_base_r   <= '0;
      r_idx      <= '0;
      r_rom_hold <= '0;
      r_ram_hold <= '0;
    end else begin
      if (i_latch) begin
        r_base_a <= i_base_a;
        r_base_b <= i_base_b;
        r_base_r <= i_base_r;
        r_idx    <= '0;
      end else if (i_inc) begin
        r_idx <= r_idx + CNT_W'(1);
      end
      if (i_sel_a) begin
        r_rom_hold <= w_addr_a;
      end else if (i_sel_b) begin
        r_rom_hold <= w_addr_b;
      end
      if (i_sel_r) begin
        r_ram_hold <= w_addr_r;
      end
    end
  end

  // Outside the write states the buses keep the last address driven
  assign o_rom_addr = i_sel_a ? w_addr_a : (i_sel_b ? w_addr_b : r_rom_hold);
  assign o_ram_addr = i_sel_r ? w_addr_r : r_ram_hold;
  assign o_idx      = r_idx;

endmodule
`default_nettype wire

// File: rtl/mult_batch_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | mult_batch_ctrl                                                    |
// | Batch sequencer for ROM -> RF -> multiplier -> RAM datapath.       |
// | Optional MULT_BATCH_CTRL_PERF_EN adds jobs_done/pairs_done counters|
// | Rev 1.0 - initial release                                          |
// +--------------------------------------------------------------------+
module mult_batch_ctrl #(
  parameter int ADDR_W    = 3,
  parameter int RF_ADDR_W = 2,
  parameter int CNT_W     = 4,
  parameter int RF_A_IDX  = mult_batch_pkg::RF_A_IDX,
  parameter int RF_B_IDX  = mult_batch_pkg::RF_B_IDX
) (
  input  wire logic        clk,
  input  wire logic        rst,
  mult_batch_ctrl_if.slave bus
`ifdef MULT_BATCH_CTRL_PERF_EN
  ,
  output logic [7:0]       jobs_done,
  output logic [7:0]       pairs_done
`endif
);
  import mult_batch_pkg::*;

  state_t           r_state;
  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] w_idx;
  logic [CNT_W-1:0] w_cnt_clamped;
  logic             w_latch;
  logic             w_last;
  logic             w_inc;
  logic             w_sel_a;
  logic             w_sel_b;
  logic             w_sel_r;

  assign w_cnt_clamped = (bus.count > CNT_W'(MAX_PAIRS)) ? CNT_W'(MAX_PAIRS) : bus.count;
  assign w_latch       = (r_state == ST_IDLE) && bus.start;
  assign w_last        = (w_idx == r_count - CNT_W'(1));
  assign w_inc         = (r_state == ST_STORE) && !w_last;
  assign w_sel_a       = (r_state == ST_LOAD_A);
  assign w_sel_b       = (r_state == ST_LOAD_B);
  assign w_sel_r       = (r_state == ST_STORE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_count <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.start) begin
            r_count <= w_cnt_clamped;
            r_state <= (w_cnt_clamped == '0) ? ST_FINISH : ST_LOAD_A;
          end
        end
        ST_LOAD_A: r_state <= ST_LOAD_B;
        ST_LOAD_B: r_state <= ST_MULT;
        ST_MULT:   r_state <= ST_STORE;
        ST_STORE:  r_state <= w_last ? ST_FINISH : ST_LOAD_A;
        default:   r_state <= ST_IDLE;
      endcase
    end
  end

  mult_batch_addr_gen #(
    .ADDR_W (ADDR_W),
    .CNT_W  (CNT_W)
  ) u_addr_gen (
    .clk        (clk),
    .rst        (rst),
    .i_latch    (w_latch),
    .i_base_a   (bus.base_a),
    .i_base_b   (bus.base_b),
    .i_base_r   (bus.base_r),
    .i_inc      (w_inc),
    .i_sel_a    (w_sel_a),
    .i_sel_b    (w_sel_b),
    .i_sel_r    (w_sel_r),
    .o_idx      (w_idx),
    .o_rom_addr (bus.rom_addr),
    .o_ram_addr (bus.ram_addr)
  );

  assign bus.rf_w      = w_sel_a || w_sel_b;
  assign bus.rf_w_addr = w_sel_a ? RF_ADDR_W'(RF_A_IDX) :
                         (w_sel_b ? RF_ADDR_W'(RF_B_IDX) : '0);
  assign bus.ram_w     = w_sel_r;
  assign bus.busy      = (r_state == ST_LOAD_A) || (r_state == ST_LOAD_B) ||
                         (r_state == ST_MULT)   || (r_state == ST_STORE);
  assign bus.done      = (r_state == ST_FINISH);

`ifdef MULT_BATCH_CTRL_PERF_EN
  logic [7:0] r_jobs_done;
  logic [7:0] r_pairs_done;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_jobs_done  <= '0;
      r_pairs_done <= '0;
    end else begin
      if (bus.done && (r_jobs_done != 8'hFF)) begin
        r_jobs_done <= r_jobs_done + 8'd1;
      end
      if (bus.ram_w && (r_pairs_done != 8'hFF)) begin
        r_pairs_done <= r_pairs_done + 8'd1;
      end
    end
  end

  assign jobs_done  = r_jobs_done;
  assign pairs_done = r_pairs_done;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mult_batch_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_mult_batch_ctrl                                                 |
// | Directed self-checking bench with ROM/RF/RAM model around the DUT  |
// | Rev 1.0 - initial release                                          |
// +--------------------------------------------------------------------+
module tb_mult_batch_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  mult_batch_ctrl_if #(.ADDR_W(3), .RF_ADDR_W(2), .CNT_W(4)) bus ();

`ifdef MULT_BATCH_CTRL_PERF_EN
  logic [7:0] jobs_done;
  logic [7:0] pairs_done;
`endif

  mult_batch_ctrl #(
    .ADDR_W    (3),
    .RF_ADDR_W (2),
    .CNT_W     (4),
    .RF_A_IDX  (0),
    .RF_B_IDX  (1)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef MULT_BATCH_CTRL_PERF_EN
    ,
    .jobs_done  (jobs_done),
    .pairs_done (pairs_done)
`endif
  );

  logic [7:0] rom [8];
  logic [7:0] rf  [4];
  logic [7:0] ram [8];

  int n_checks = 0;
  int n_errors = 0;

  int         g_done_cyc, g_done_n, g_nrf, g_nram, g_busy_n, g_ram_cyc;
  int         g_rom_seq [64];
  int         g_rf_idx  [64];
  int         g_ram_seq [64];
  logic [7:0] g_rf_dat  [64];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Start is held during cycle 0; cycle c is observed at its falling edge
  task automatic run_job(input logic [2:0] ba, input logic [2:0] bb, input logic [2:0] br,
                         input logic [3:0] cnt, input int ncyc, input int extra_start,
                         input int rst_at);
    logic [15:0] prod;
    @(negedge clk);
    bus.base_a = ba;
    bus.base_b = bb;
    bus.base_r = br;
    bus.count  = cnt;
    bus.start  = 1'b1;
    g_done_cyc = -1; g_done_n = 0; g_nrf = 0; g_nram = 0; g_busy_n = 0; g_ram_cyc = -1;
    for (int c = 1; c <= ncyc; c++) begin
      @(negedge clk);
      bus.start = (c == extra_start);
      if (bus.rf_w === 1'b1) begin
        g_rom_seq[g_nrf]    = int'(bus.rom_addr);
        g_rf_idx[g_nrf]     = int'(bus.rf_w_addr);
        g_rf_dat[g_nrf]     = rom[bus.rom_addr];
        rf[bus.rf_w_addr]   = rom[bus.rom_addr];
        g_nrf++;
      end
      if (bus.ram_w === 1'b1) begin
        if (g_nram == 0) g_ram_cyc = c;
        g_ram_seq[g_nram] = int'(bus.ram_addr);
        prod = rf[0] * rf[1];
        ram[bus.ram_addr] = prod[7:0];
        g_nram++;
      end
      if (bus.busy === 1'b1) g_busy_n++;
      if (bus.done === 1'b1) begin
        if (g_done_n == 0) g_done_cyc = c;
        g_done_n++;
      end
      if (c == rst_at) begin
        rst = 1'b1;
        #1;
        chk("rst_async_rom_addr", 32'(bus.rom_addr), 0);
        chk("rst_async_strobes",
            32'({bus.rf_w, bus.rf_w_addr, bus.ram_addr, bus.ram_w, bus.busy, bus.done}), 0);
      end else if (c == rst_at + 1) begin
        rst = 1'b0;
      end
    end
  endtask

  initial begin
    rom[0] = 8'd3;  rom[1] = 8'd2;  rom[2] = 8'd6;  rom[3] = 8'd9;
    rom[4] = 8'd5;  rom[5] = 8'd11; rom[6] = 8'd4;  rom[7] = 8'd13;
    for (int i = 0; i < 4; i++) rf[i] = 8'd0;
    for (int i = 0; i < 8; i++) ram[i] = 8'd0;
    bus.start = 1'b0; bus.base_a = '0; bus.base_b = '0; bus.base_r = '0; bus.count = '0;

    #3;
    chk("reset_outputs",
        32'({bus.rom_addr, bus.rf_w, bus.rf_w_addr, bus.ram_addr, bus.ram_w, bus.busy, bus.done}), 0);
    @(negedge clk);
    rst = 1'b0;

    // single pair: 3 * 5 into RAM[2]
    run_job(3'd0, 3'd4, 3'd2, 4'd1, 5, 0, 0);
    chk("single_rf0_idx", g_rf_idx[0], 0);
    chk("single_rf0_dat", 32'(g_rf_dat[0]), 3);
    chk("single_rf1_idx", g_rf_idx[1], 1);
    chk("single_rf1_dat", 32'(g_rf_dat[1]), 5);
    chk("single_ram_cyc", g_ram_cyc, 4);
    chk("single_ram2", 32'(ram[2]), 15);
    chk("single_done_cyc", g_done_cyc, 5);
    chk("single_busy_n", g_busy_n, 4);

    // wrap-around addressing
    run_job(3'd6, 3'd1, 3'd7, 4'd3, 13, 0, 0);
    chk("wrap_nrf", g_nrf, 6);
    chk("wrap_rom0", g_rom_seq[0], 6);
    chk("wrap_rom1", g_rom_seq[1], 1);
    chk("wrap_rom2", g_rom_seq[2], 7);
    chk("wrap_rom3", g_rom_seq[3], 2);
    chk("wrap_rom4", g_rom_seq[4], 0);
    chk("wrap_rom5", g_rom_seq[5], 3);
    chk("wrap_ram0", g_ram_seq[0], 7);
    chk("wrap_ram1", g_ram_seq[1], 0);
    chk("wrap_ram2", g_ram_seq[2], 1);
    chk("wrap_data7", 32'(ram[7]), 8);
    chk("wrap_data0", 32'(ram[0]), 78);
    chk("wrap_data1", 32'(ram[1]), 27);
    chk("wrap_done_cyc", g_done_cyc, 13);

    // count = 0
    run_job(3'd3, 3'd3, 3'd3, 4'd0, 3, 0, 0);
    chk("zero_done_cyc", g_done_cyc, 1);
    chk("zero_nrf", g_nrf, 0);
    chk("zero_nram", g_nram, 0);
    chk("zero_busy_n", g_busy_n, 0);

    // count = 12 clamps to 8
    run_job(3'd0, 3'd0, 3'd0, 4'd12, 33, 0, 0);
    chk("clamp_nram", g_nram, 8);
    chk("clamp_last_ram", g_ram_seq[7], 7);
    chk("clamp_done_cyc", g_done_cyc, 33);

    // start while busy is dropped; next start right after done is taken
    run_job(3'd2, 3'd5, 3'd4, 4'd2, 9, 2, 0);
    chk("busy_start_nram", g_nram, 2);
    chk("busy_start_done_cyc", g_done_cyc, 9);
    run_job(3'd1, 3'd1, 3'd5, 4'd1, 5, 0, 0);
    chk("after_done_ram_addr", g_ram_seq[0], 5);
    chk("after_done_done_cyc", g_done_cyc, 5);

    // start during FINISH is not queued
    run_job(3'd0, 3'd4, 3'd6, 4'd1, 10, 5, 0);
    chk("finish_start_nram", g_nram, 1);
    chk("finish_start_busy_n", g_busy_n, 4);
    chk("finish_start_done_n", g_done_n, 1);

    // reset during MULT of pair 2 of 3
    run_job(3'd0, 3'd4, 3'd0, 4'd3, 12, 0, 7);
    chk("midrst_nrf", g_nrf, 4);
    chk("midrst_nram", g_nram, 1);
    chk("midrst_done_n", g_done_n, 0);
    ram[3] = 8'd0;
    run_job(3'd0, 3'd4, 3'd3, 4'd1, 5, 0, 0);
    chk("postrst_rom0", g_rom_seq[0], 0);
    chk("postrst_ram_addr", g_ram_seq[0], 3);
    chk("postrst_ram3", 32'(ram[3]), 15);
    chk("postrst_done_cyc", g_done_cyc, 5);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
